// File: rtl/fractal_sync_arb.sv
// fractal_sync_arb: round-robin arbiter and response router for one fractal-sync core-control port.
// Define FRACTAL_SYNC_ARB_OUT_REG_EN to insert a one-entry output register (default: combinational grant with lock).
module fractal_sync_arb #(
    parameter  int N_PORTS   = 4,
    parameter  int LVL_W     = 4,
    parameter  int ID_W      = 8,
    parameter  int MAX_OUTST = 2,
    parameter  int OUTST_W   = $clog2(MAX_OUTST + 1),
    localparam int IDX_W     = $clog2(N_PORTS)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [N_PORTS-1:0]       req_valid_i,
    input  logic [N_PORTS*LVL_W-1:0] req_lvl_i,
    input  logic [N_PORTS*ID_W-1:0]  req_id_i,
    output logic [N_PORTS-1:0]       req_ready_o,
    output logic                     out_valid_o,
    output logic [LVL_W-1:0]         out_lvl_o,
    output logic [ID_W-1:0]          out_id_o,
    output logic [IDX_W-1:0]         out_src_o,
    input  logic                     out_ready_i,
    input  logic                     rsp_valid_i,
    input  logic [IDX_W-1:0]         rsp_dst_i,
    input  logic                     rsp_err_i,
    output logic [N_PORTS-1:0]       rsp_valid_o,
    output logic [N_PORTS-1:0]       rsp_err_o,
    output logic                     err_o
);

    logic [OUTST_W-1:0]   r_outst [N_PORTS];
    logic [IDX_W-1:0]     r_ptr;
    logic [N_PORTS-1:0]   r_rsp_valid;
    logic [N_PORTS-1:0]   r_rsp_err;
    logic                 r_err;

    logic [N_PORTS-1:0]   w_eligible;
    logic [2*N_PORTS-1:0] w_elig_rot;
    logic [IDX_W-1:0]     w_off;
    logic [IDX_W:0]       w_sum;
    logic [IDX_W-1:0]     w_scan_idx;
    logic                 w_any;
    logic [IDX_W-1:0]     w_grant_idx;
    logic [N_PORTS-1:0]   w_grant_oh;
    logic                 w_accept;
    logic [LVL_W-1:0]     w_sel_lvl;
    logic [ID_W-1:0]      w_sel_id;
    logic [N_PORTS-1:0]   w_rsp_dec;
    logic                 w_rsp_ok;

    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            w_eligible[p] = req_valid_i[p] && (r_outst[p] < OUTST_W'(MAX_OUTST));
        end
    end

    // Rotate eligibility so bit 0 is the pointer's port; the lowest set bit is the winner offset.
    assign w_elig_rot = {w_eligible, w_eligible} >> r_ptr;
    assign w_any      = |w_eligible;

    // NOTE: every always_comb output gets a default before any conditional assignment, so no latch is inferred.
    always_comb begin
        w_off = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (w_elig_rot[i]) w_off = IDX_W'(i);
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= (IDX_W + 1)'(N_PORTS)) w_scan_idx = IDX_W'(w_sum - (IDX_W + 1)'(N_PORTS));
        else                                 w_scan_idx = w_sum[IDX_W-1:0];
    end

    always_comb begin
        w_sel_lvl = '0;
        w_sel_id  = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            w_grant_oh[p] = (w_grant_idx == IDX_W'(p));
            if (w_grant_oh[p]) begin
                w_sel_lvl = req_lvl_i[p*LVL_W +: LVL_W];
                w_sel_id  = req_id_i[p*ID_W +: ID_W];
            end
        end
    end

`ifdef FRACTAL_SYNC_ARB_OUT_REG_EN
    logic             r_ov;
    logic [LVL_W-1:0] r_lvl;
    logic [ID_W-1:0]  r_id;
    logic [IDX_W-1:0] r_src;

    // Accept when the register is empty or draining this cycle; the register carries the payload.
    assign w_grant_idx = w_scan_idx;
    assign w_accept    = w_any && (!r_ov || out_ready_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ov  <= 1'b0;
            r_lvl <= '0;
            r_id  <= '0;
            r_src <= '0;
        end else if (w_accept) begin
            r_ov  <= 1'b1;
            r_lvl <= w_sel_lvl;
            r_id  <= w_sel_id;
            r_src <= w_grant_idx;
        end else if (out_ready_i) begin
            r_ov  <= 1'b0;
        end
    end

    assign out_valid_o = r_ov;
    assign out_lvl_o   = r_lvl;
    assign out_id_o    = r_id;
    assign out_src_o   = r_src;
`else
    logic             r_lock;
    logic [IDX_W-1:0] r_lock_idx;
    logic             w_out_valid;

    // A stalled grant is pinned so a newly eligible port cannot swap the payload mid-handshake.
    assign w_grant_idx = r_lock ? r_lock_idx : w_scan_idx;
    assign w_out_valid = r_lock || w_any;
    assign w_accept    = w_out_valid && out_ready_i;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else if (w_out_valid && !out_ready_i) begin
            r_lock     <= 1'b1;
            r_lock_idx <= w_grant_idx;
        end else if (w_accept) begin
            r_lock     <= 1'b0;
        end
    end

    assign out_valid_o = w_out_valid;
    assign out_lvl_o   = w_out_valid ? w_sel_lvl : '0;
    assign out_id_o    = w_out_valid ? w_sel_id : '0;
    assign out_src_o   = w_out_valid ? w_grant_idx : '0;
`endif

    assign req_ready_o = w_accept ? w_grant_oh : '0;

    // A destination outside the port range never matches, so it is rejected like an idle port.
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            w_rsp_dec[p] = rsp_valid_i && (rsp_dst_i == IDX_W'(p)) && (r_outst[p] != '0);
        end
    end
    assign w_rsp_ok = |w_rsp_dec;

    // NOTE: the outstanding counters are a few flops each, so they are reset explicitly rather than left to a RAM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int p = 0; p < N_PORTS; p++) r_outst[p] <= '0;
            r_ptr       <= '0;
            r_rsp_valid <= '0;
            r_rsp_err   <= '0;
            r_err       <= 1'b0;
        end else begin
            for (int p = 0; p < N_PORTS; p++) begin
                case ({w_accept && w_grant_oh[p], w_rsp_dec[p]})
                    2'b10:   r_outst[p] <= r_outst[p] + 1'b1;
                    2'b01:   r_outst[p] <= r_outst[p] - 1'b1;
                    default: r_outst[p] <= r_outst[p];
                endcase
            end
            if (w_accept) begin
                r_ptr <= (w_grant_idx == IDX_W'(N_PORTS - 1)) ? '0 : w_grant_idx + 1'b1;
            end
            r_rsp_valid <= w_rsp_dec;
            r_rsp_err   <= rsp_err_i ? w_rsp_dec : '0;
            if (rsp_valid_i && !w_rsp_ok) r_err <= 1'b1;
        end
    end

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_err_o   = r_rsp_err;
    assign err_o       = r_err;

endmodule

// File: tb/tb_fractal_sync_arb.sv
// Self-checking bench for fractal_sync_arb: grant scoreboard checked on the falling edge plus scenario tasks.
// A second 3-port instance exercises responses whose destination lies outside the port range.
module tb_fractal_sync_arb;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [3:0]  req_valid_i = '0;
    logic [15:0] req_lvl_i;
    logic [31:0] req_id_i;
    logic [3:0]  req_ready_o;
    logic        out_valid_o;
    logic [3:0]  out_lvl_o;
    logic [7:0]  out_id_o;
    logic [1:0]  out_src_o;
    logic        out_ready_i = 1'b0;
    logic        rsp_valid_i = 1'b0;
    logic [1:0]  rsp_dst_i = '0;
    logic        rsp_err_i = 1'b0;
    logic [3:0]  rsp_valid_o;
    logic [3:0]  rsp_err_o;
    logic        err_o;

    logic [2:0]  req_valid3 = '0;
    logic [11:0] req_lvl3 = '0;
    logic [23:0] req_id3 = '0;
    logic [2:0]  req_ready3;
    logic        out_valid3;
    logic [3:0]  out_lvl3;
    logic [7:0]  out_id3;
    logic [1:0]  out_src3;
    logic        rsp_valid3 = 1'b0;
    logic [1:0]  rsp_dst3 = '0;
    logic [2:0]  rsp_valid_o3;
    logic [2:0]  rsp_err_o3;
    logic        err3;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [1:0]  exp_q[$];
    logic [1:0]  mon_e;

    always #5 clk_i = ~clk_i;

    fractal_sync_arb u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_lvl_i(req_lvl_i), .req_id_i(req_id_i), .req_ready_o(req_ready_o),
        .out_valid_o(out_valid_o), .out_lvl_o(out_lvl_o), .out_id_o(out_id_o), .out_src_o(out_src_o),
        .out_ready_i(out_ready_i),
        .rsp_valid_i(rsp_valid_i), .rsp_dst_i(rsp_dst_i), .rsp_err_i(rsp_err_i),
        .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o), .err_o(err_o)
    );

    fractal_sync_arb #(.N_PORTS(3)) u_dut3 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid3), .req_lvl_i(req_lvl3), .req_id_i(req_id3), .req_ready_o(req_ready3),
        .out_valid_o(out_valid3), .out_lvl_o(out_lvl3), .out_id_o(out_id3), .out_src_o(out_src3),
        .out_ready_i(1'b0),
        .rsp_valid_i(rsp_valid3), .rsp_dst_i(rsp_dst3), .rsp_err_i(1'b0),
        .rsp_valid_o(rsp_valid_o3), .rsp_err_o(rsp_err_o3), .err_o(err3)
    );

    function automatic logic [3:0] exp_lvl(input logic [1:0] src);
        return 4'(src) + 4'd1;
    endfunction

    function automatic logic [7:0] exp_id(input logic [1:0] src);
        return {2'b00, src, 4'h5};
    endfunction

    // Every output handshake must match the oldest expected grant.
    always @(negedge clk_i) begin
        if (rst_ni && out_valid_o && out_ready_i) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_grant: got src %0d, want no grant", out_src_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_src_o !== mon_e || out_lvl_o !== exp_lvl(mon_e) || out_id_o !== exp_id(mon_e)) begin
                    n_bad++;
                    $display("FAIL grant_payload: got src %0d lvl %h id %h, want src %0d lvl %h id %h",
                             out_src_o, out_lvl_o, out_id_o, mon_e, exp_lvl(mon_e), exp_id(mon_e));
                end
`ifndef FRACTAL_SYNC_ARB_OUT_REG_EN
                n_cmp++;
                if (req_ready_o !== (4'b0001 << mon_e)) begin
                    n_bad++;
                    $display("FAIL grant_ready: got %b, want %b", req_ready_o, 4'b0001 << mon_e);
                end
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_drained(input string name);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain: got %0d grants still expected, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic send_rsp(input logic [1:0] dst, input logic err, input logic exp_ok);
        logic [3:0] want;
        want        = exp_ok ? (4'b0001 << dst) : 4'b0000;
        rsp_valid_i = 1'b1;
        rsp_dst_i   = dst;
        rsp_err_i   = err;
        tick();
        rsp_valid_i = 1'b0;
        rsp_err_i   = 1'b0;
        n_cmp++;
        if (rsp_valid_o !== want) begin
            n_bad++;
            $display("FAIL rsp_valid dst %0d: got %b, want %b", dst, rsp_valid_o, want);
        end
        n_cmp++;
        if (rsp_err_o !== (err ? want : 4'b0000)) begin
            n_bad++;
            $display("FAIL rsp_err dst %0d: got %b, want %b", dst, rsp_err_o, err ? want : 4'b0000);
        end
        if (!exp_ok) begin
            n_cmp++;
            if (err_o !== 1'b1) begin
                n_bad++;
                $display("FAIL rsp_invalid_err dst %0d: got %b, want 1", dst, err_o);
            end
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        req_valid_i = '0;
        out_ready_i = 1'b0;
        rsp_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        n_cmp++;
        if ({req_ready_o, out_valid_o, out_lvl_o, out_id_o, out_src_o, rsp_valid_o, rsp_err_o, err_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ready %b ov %b lvl %h id %h src %0d rv %b re %b err %b, want all 0",
                     req_ready_o, out_valid_o, out_lvl_o, out_id_o, out_src_o, rsp_valid_o, rsp_err_o, err_o);
        end
        n_cmp++;
        if (err3 !== 1'b0 || rsp_valid_o3 !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_dut3: got err %b rv %b, want 0 0", err3, rsp_valid_o3);
        end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_round_robin();
        req_valid_i = 4'b1111;
        out_ready_i = 1'b1;
        for (int p = 0; p < 4; p++) exp_q.push_back(2'(p));
        repeat (4) tick();
        // Pointer must be back at 0: a stalled all-valid request presents port 0.
        out_ready_i = 1'b0;
        #1;
        n_cmp++;
        if (out_valid_o !== 1'b1 || out_src_o !== 2'd0) begin
            n_bad++;
            $display("FAIL rr_ptr_wrap: got valid %b src %0d, want 1 0", out_valid_o, out_src_o);
        end
        tick();
        out_ready_i = 1'b1;
        exp_q.push_back(2'd0);
        tick();
        req_valid_i = '0;
        out_ready_i = 1'b0;
        check_drained("rr");
        send_rsp(2'd0, 1'b0, 1'b1);
        send_rsp(2'd0, 1'b1, 1'b1);
        send_rsp(2'd1, 1'b0, 1'b1);
        send_rsp(2'd2, 1'b1, 1'b1);
        send_rsp(2'd3, 1'b0, 1'b1);
    endtask

    task automatic test_lock();
        // A grant to port 3 leaves the pointer at 0, so port 0 would win without the lock.
        req_valid_i = 4'b1000;
        out_ready_i = 1'b1;
        exp_q.push_back(2'd3);
        tick();
        req_valid_i = 4'b0100;
        out_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) req_valid_i = 4'b0101;
            #1;
            n_cmp++;
            if (out_valid_o !== 1'b1 || out_src_o !== 2'd2 || req_ready_o !== 4'b0000) begin
                n_bad++;
                $display("FAIL lock_hold cycle %0d: got valid %b src %0d ready %b, want 1 2 0000",
                         c, out_valid_o, out_src_o, req_ready_o);
            end
            tick();
        end
        out_ready_i = 1'b1;
        exp_q.push_back(2'd2);
        tick();
        req_valid_i = 4'b0001;
        exp_q.push_back(2'd0);
        tick();
        req_valid_i = '0;
        out_ready_i = 1'b0;
        check_drained("lock");
    endtask

    task automatic test_same_cycle();
        // outst[3]=1: grant and response on port 3 together leave it at 1.
        req_valid_i = 4'b1000;
        out_ready_i = 1'b1;
        rsp_valid_i = 1'b1;
        rsp_dst_i   = 2'd3;
        rsp_err_i   = 1'b0;
        exp_q.push_back(2'd3);
        tick();
        rsp_valid_i = 1'b0;
        n_cmp++;
        if (rsp_valid_o !== 4'b1000 || rsp_err_o !== 4'b0000) begin
            n_bad++;
            $display("FAIL same_cycle_rsp: got rv %b re %b, want 1000 0000", rsp_valid_o, rsp_err_o);
        end
        exp_q.push_back(2'd3);
        tick();
        n_cmp++;
        if (out_valid_o !== 1'b0 || req_ready_o !== 4'b0000) begin
            n_bad++;
            $display("FAIL same_cycle_limit: got valid %b ready %b, want 0 0000", out_valid_o, req_ready_o);
        end
        req_valid_i = '0;
        out_ready_i = 1'b0;
        check_drained("same_cycle");
        send_rsp(2'd0, 1'b0, 1'b1);
        send_rsp(2'd2, 1'b0, 1'b1);
        send_rsp(2'd3, 1'b1, 1'b1);
        send_rsp(2'd3, 1'b0, 1'b1);
    endtask

    task automatic test_outstanding();
        req_valid_i = 4'b0010;
        out_ready_i = 1'b1;
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd1);
        repeat (2) tick();
        for (int c = 0; c < 2; c++) begin
            n_cmp++;
            if (out_valid_o !== 1'b0 || req_ready_o !== 4'b0000) begin
                n_bad++;
                $display("FAIL outst_block cycle %0d: got valid %b ready %b, want 0 0000", c, out_valid_o, req_ready_o);
            end
            if (c == 0) tick();
        end
        rsp_valid_i = 1'b1;
        rsp_dst_i   = 2'd1;
        rsp_err_i   = 1'b1;
        tick();
        rsp_valid_i = 1'b0;
        rsp_err_i   = 1'b0;
        n_cmp++;
        if (rsp_valid_o !== 4'b0010 || rsp_err_o !== 4'b0010) begin
            n_bad++;
            $display("FAIL outst_rsp_err: got rv %b re %b, want 0010 0010", rsp_valid_o, rsp_err_o);
        end
        exp_q.push_back(2'd1);
        tick();
        req_valid_i = '0;
        out_ready_i = 1'b0;
        check_drained("outst");
        send_rsp(2'd1, 1'b0, 1'b1);
        send_rsp(2'd1, 1'b0, 1'b1);
    endtask

    task automatic test_mid_reset();
        req_valid_i = 4'b0001;
        out_ready_i = 1'b1;
        exp_q.push_back(2'd0);
        tick();
        req_valid_i = '0;
        out_ready_i = 1'b0;
        check_drained("mid_reset");
        rst_ni = 1'b0;
        #1;
        n_cmp++;
        if (out_valid_o !== 1'b0 || err_o !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_clear: got valid %b err %b, want 0 0", out_valid_o, err_o);
        end
        tick();
        rst_ni = 1'b1;
        tick();
        send_rsp(2'd0, 1'b0, 1'b0);
        test_reset();
    endtask

    task automatic test_out_reg();
        req_valid_i = 4'b0011;
        out_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back(2'(k % 2));
        #1;
        n_cmp++;
        if (out_valid_o !== 1'b0 || req_ready_o !== 4'b0001) begin
            n_bad++;
            $display("FAIL out_reg_first: got valid %b ready %b, want 0 0001", out_valid_o, req_ready_o);
        end
        for (int c = 1; c <= 5; c++) begin
            tick();
            n_cmp++;
            if (out_valid_o !== (c <= 4)) begin
                n_bad++;
                $display("FAIL out_reg_stream cycle %0d: got valid %b, want %b", c, out_valid_o, c <= 4);
            end
        end
        req_valid_i = '0;
        out_ready_i = 1'b0;
        check_drained("out_reg");
        send_rsp(2'd0, 1'b0, 1'b1);
        send_rsp(2'd0, 1'b1, 1'b1);
        send_rsp(2'd1, 1'b0, 1'b1);
        send_rsp(2'd1, 1'b0, 1'b1);
    endtask

    task automatic test_invalid_rsp();
        n_cmp++;
        if (err_o !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clean: got %b, want 0", err_o);
        end
        send_rsp(2'd0, 1'b1, 1'b0);
        repeat (3) tick();
        n_cmp++;
        if (err_o !== 1'b1) begin
            n_bad++;
            $display("FAIL err_sticky: got %b, want 1", err_o);
        end
        rsp_valid3 = 1'b1;
        rsp_dst3   = 2'd3;
        tick();
        rsp_valid3 = 1'b0;
        n_cmp++;
        if (rsp_valid_o3 !== 3'b000 || err3 !== 1'b1) begin
            n_bad++;
            $display("FAIL dst_out_of_range: got rv %b err %b, want 000 1", rsp_valid_o3, err3);
        end
        rst_ni = 1'b0;
        #1;
        n_cmp++;
        if (err_o !== 1'b0 || err3 !== 1'b0) begin
            n_bad++;
            $display("FAIL err_reset: got %b %b, want 0 0", err_o, err3);
        end
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        for (int p = 0; p < 4; p++) begin
            req_lvl_i[p*4 +: 4] = exp_lvl(2'(p));
            req_id_i[p*8 +: 8]  = exp_id(2'(p));
        end
        test_reset();
`ifdef FRACTAL_SYNC_ARB_OUT_REG_EN
        test_out_reg();
`else
        test_round_robin();
        test_lock();
        test_same_cycle();
        test_outstanding();
        test_mid_reset();
`endif
        test_invalid_rsp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
